// File: rtl/farm_sensor_pkg.sv
// Shared types and constants for the farm-road sensor front end.
package farm_sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        REQ   = 2'd2,
        SERVE = 2'd3
    } state_t;

    localparam int unsigned DEB_CYC_DEF  = 4;
    localparam int unsigned PASS_CYC_DEF = 3;
    localparam int unsigned REQ_DLY_DEF  = 2;
    localparam int unsigned CNT_W_DEF    = 4;

    // Timer width able to hold 0..x-1; never narrower than one bit.
    function automatic int unsigned tmr_w(input int unsigned x);
        int unsigned v;
        v = (x < 2) ? 2 : x;
        return $clog2(v);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer, debounce counter and registered arrival pulse.
module sensor_debounce
    import farm_sensor_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise
);
    localparam int unsigned W = tmr_w(DEB_CYC);

    logic         r_s1, r_s2, r_lvl, r_rise;
    logic [W-1:0] r_cnt;
    logic         w_diff, w_flip;

    assign w_diff = (r_s2 != r_lvl);
    assign w_flip = w_diff && (r_cnt == W'(DEB_CYC - 1));

    // Plain flop chain into the clock domain, nothing between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // Level flips only after DEB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_rise <= w_flip && r_s2;
            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
            if (w_flip) begin
                r_lvl <= r_s2;
            end
        end
    end

    assign lvl  = r_lvl;
    assign rise = r_rise;

endmodule

// File: rtl/farm_sensor_ctrl.sv
// Farm-road vehicle queue: counts arrivals/departures and raises request c.
module farm_sensor_ctrl
    import farm_sensor_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned PASS_CYC = PASS_CYC_DEF,
    parameter int unsigned REQ_DLY  = REQ_DLY_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic             FG,
    output logic             c,
    output logic [CNT_W-1:0] car_cnt,
    output logic             det_pulse,
    output logic             ovf
);
    localparam int unsigned      PASS_W   = tmr_w(PASS_CYC);
    localparam int unsigned      ARM_W    = tmr_w(REQ_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic              w_lvl, w_rise, w_arr, w_dep, w_cnt_nz;
    state_t            r_state, w_state_nx;
    logic              r_c, w_c_nx, r_det, r_ovf, w_ovf_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [PASS_W-1:0] r_pass, w_pass_nx;
    logic [ARM_W-1:0]  r_arm, w_arm_nx;

    sensor_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (sensor_raw),
        .lvl  (w_lvl),
        .rise (w_rise)
    );

    // rise is only asserted in the first cycle the debounced level is high.
    assign w_arr    = w_rise && w_lvl;
    assign w_cnt_nz = (r_cnt != CNT_ZERO);
    assign w_dep    = FG && w_cnt_nz && (r_pass == PASS_W'(PASS_CYC - 1));

    // Queue count: simultaneous arrival and departure cancel out.
    always_comb begin
        w_cnt_nx = r_cnt;
        w_ovf_nx = r_ovf;
        if (w_arr && !w_dep) begin
            if (r_cnt == CNT_MAX) begin
                w_ovf_nx = 1'b1;
            end else begin
                w_cnt_nx = r_cnt + CNT_W'(1);
            end
        end else if (w_dep && !w_arr) begin
            if (w_cnt_nz) begin
                w_cnt_nx = r_cnt - CNT_W'(1);
            end
        end
    end

    // Departure timer runs only while farm green and someone is waiting.
    always_comb begin
        w_pass_nx = '0;
        if (FG && w_cnt_nz && !w_dep) begin
            w_pass_nx = r_pass + PASS_W'(1);
        end
    end

    // Request FSM; c follows the state being left, so REQ shows c one edge later
    // while SERVE drops c on the same edge the queue empties.
    always_comb begin
        w_state_nx = r_state;
        w_arm_nx   = '0;
        w_c_nx     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cnt_nx != CNT_ZERO) begin
                    w_state_nx = ARM;
                end
            end
            ARM: begin
                if (FG) begin
                    w_state_nx = SERVE;
                end else if (r_arm == ARM_W'(REQ_DLY - 1)) begin
                    w_state_nx = REQ;
                end else begin
                    w_arm_nx = r_arm + ARM_W'(1);
                end
            end
            REQ: begin
                w_c_nx = 1'b1;
                if (FG) begin
                    w_state_nx = SERVE;
                end
            end
            SERVE: begin
                w_c_nx = (w_cnt_nx != CNT_ZERO);
                if (!FG) begin
                    w_state_nx = (w_cnt_nx != CNT_ZERO) ? REQ : IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, request and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_c     <= 1'b0;
            r_arm   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_c     <= w_c_nx;
            r_arm   <= w_arm_nx;
        end
    end

    // Queue count, sticky overflow, departure timer and arrival pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_pass <= '0;
            r_det  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nx;
            r_ovf  <= w_ovf_nx;
            r_pass <= w_pass_nx;
            r_det  <= w_arr;
        end
    end

    assign c         = r_c;
    assign car_cnt   = r_cnt;
    assign det_pulse = r_det;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Directed scenarios plus randomized run against a behavioural queue model.
module tb_farm_sensor_ctrl;

    localparam int DEB_CYC  = 4;
    localparam int PASS_CYC = 3;
    localparam int REQ_DLY  = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sensor_raw = 1'b0;
    logic             FG = 1'b0;
    logic             c;
    logic [CNT_W-1:0] car_cnt;
    logic             det_pulse;
    logic             ovf;

    int n_total = 0;
    int n_bad   = 0;

    farm_sensor_ctrl #(
        .DEB_CYC  (DEB_CYC),
        .PASS_CYC (PASS_CYC),
        .REQ_DLY  (REQ_DLY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .FG         (FG),
        .c          (c),
        .car_cnt    (car_cnt),
        .det_pulse  (det_pulse),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: queue of waiting cars plus request phase.
    localparam int P_IDLE = 0, P_ARM = 1, P_REQ = 2, P_SERVE = 3;
    int m_sync [2];
    int m_lvl, m_run, m_rise, m_det, m_cnt, m_ovf, m_pass, m_phase, m_wait, m_c;

    task automatic model_reset();
        m_sync[0] = 0; m_sync[1] = 0;
        m_lvl = 0; m_run = 0; m_rise = 0; m_det = 0; m_cnt = 0; m_ovf = 0;
        m_pass = 0; m_phase = P_IDLE; m_wait = 0; m_c = 0;
    endtask

    task automatic model_step();
        int arr, dep, cnt_n, phase_n, wait_n, lvl_n, run_n, rise_n;
        if (rst) begin
            model_reset();
            return;
        end
        arr   = m_rise;
        dep   = (FG && m_cnt > 0 && m_pass == PASS_CYC - 1) ? 1 : 0;
        cnt_n = m_cnt;
        if (arr && !dep) begin
            if (m_cnt == CNT_MAX) m_ovf = 1;
            else cnt_n = m_cnt + 1;
        end else if (dep && !arr) begin
            cnt_n = m_cnt - 1;
        end
        m_c = (m_phase == P_REQ || (m_phase == P_SERVE && cnt_n != 0)) ? 1 : 0;
        phase_n = m_phase;
        wait_n  = 0;
        case (m_phase)
            P_IDLE:  if (cnt_n > 0) phase_n = P_ARM;
            P_ARM:   if (FG) phase_n = P_SERVE;
                     else if (m_wait == REQ_DLY - 1) phase_n = P_REQ;
                     else wait_n = m_wait + 1;
            P_REQ:   if (FG) phase_n = P_SERVE;
            default: if (!FG) phase_n = (cnt_n > 0) ? P_REQ : P_IDLE;
        endcase
        m_pass = (FG && m_cnt > 0 && !dep) ? m_pass + 1 : 0;
        lvl_n = m_lvl; rise_n = 0; run_n = 0;
        if (m_sync[1] != m_lvl) begin
            if (m_run == DEB_CYC - 1) begin
                lvl_n  = m_sync[1];
                rise_n = m_sync[1];
            end else begin
                run_n = m_run + 1;
            end
        end
        m_sync[1] = m_sync[0];
        m_sync[0] = sensor_raw;
        m_lvl = lvl_n; m_run = run_n; m_rise = rise_n; m_det = arr;
        m_cnt = cnt_n; m_phase = phase_n; m_wait = wait_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sensor_raw = 1'b0; FG = 1'b0;
        model_reset();
        tick(); tick();
        n_total++;
        if ({c, car_cnt, det_pulse, ovf} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got c=%b cnt=%0d det=%b ovf=%b want all 0",
                     c, car_cnt, det_pulse, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic arrive();
        sensor_raw = 1'b1;
        repeat (6) tick();
        sensor_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_first_arrival();
        sensor_raw = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (n == 10) sensor_raw = 1'b0;
            tick();
            n_total++;
            if (det_pulse !== (n == 6)) begin
                n_bad++;
                $display("FAIL t1_det edge=%0d got=%b want=%b", n, det_pulse, (n == 6));
            end
            n_total++;
            if (car_cnt !== ((n >= 6) ? 4'd1 : 4'd0)) begin
                n_bad++;
                $display("FAIL t1_cnt edge=%0d got=%0d want=%0d", n, car_cnt, (n >= 6));
            end
            n_total++;
            if (c !== (n >= 9)) begin
                n_bad++;
                $display("FAIL t1_c edge=%0d got=%b want=%b", n, c, (n >= 9));
            end
        end
    endtask

    task automatic test_glitch();
        sensor_raw = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n == 3) sensor_raw = 1'b0;
            tick();
            n_total++;
            if ({det_pulse, c, car_cnt} !== 6'd0) begin
                n_bad++;
                $display("FAIL glitch edge=%0d got det=%b c=%b cnt=%0d want 0 0 0",
                         n, det_pulse, c, car_cnt);
            end
        end
    endtask

    task automatic test_drain();
        repeat (3) arrive();
        repeat (3) tick();
        n_total++;
        if (car_cnt !== 4'd3 || c !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_start got cnt=%0d c=%b want cnt=3 c=1", car_cnt, c);
        end
        FG = 1'b1;
        for (int m = 0; m < 9; m++) begin
            tick();
            n_total++;
            if (car_cnt !== 4'(3 - (m + 1) / 3) || c !== (m < 8)) begin
                n_bad++;
                $display("FAIL drain edge=%0d got cnt=%0d c=%b want cnt=%0d c=%b",
                         m, car_cnt, c, 3 - (m + 1) / 3, (m < 8));
            end
        end
        FG = 1'b0;
        repeat (4) begin
            tick();
            n_total++;
            if (c !== 1'b0 || car_cnt !== 4'd0) begin
                n_bad++;
                $display("FAIL drain_idle got c=%b cnt=%0d want c=0 cnt=0", c, car_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        repeat (4) arrive();
        repeat (4) tick();
        n_total++;
        if (car_cnt !== 4'd4 || c !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_start got cnt=%0d c=%b want cnt=4 c=1", car_cnt, c);
        end
        FG = 1'b1;
        for (int m = 0; m < 11; m++) begin
            if (m == 6) FG = 1'b0;
            tick();
            n_total++;
            if (c !== 1'b1) begin
                n_bad++;
                $display("FAIL timeout_c edge=%0d got=%b want=1", m, c);
            end
        end
        n_total++;
        if (car_cnt !== 4'd2) begin
            n_bad++;
            $display("FAIL timeout_cnt got=%0d want=2", car_cnt);
        end
    endtask

    task automatic test_back_to_back();
        sensor_raw = 1'b1;
        for (int n = 0; n < 7; n++) begin
            if (n == 4) FG = 1'b1;
            tick();
            if (n >= 5) begin
                n_total++;
                if (car_cnt !== 4'd2 || det_pulse !== (n == 6)) begin
                    n_bad++;
                    $display("FAIL coincide edge=%0d got cnt=%0d det=%b want cnt=2 det=%b",
                             n, car_cnt, det_pulse, (n == 6));
                end
            end
        end
        FG = 1'b0;
        sensor_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) begin
            sensor_raw = 1'b1;
            repeat (6) tick();
            sensor_raw = 1'b0;
            tick();
            n_total++;
            if (det_pulse !== 1'b1 || car_cnt !== 4'((i + 1 > CNT_MAX) ? CNT_MAX : i + 1)
                || ovf !== (i == 15)) begin
                n_bad++;
                $display("FAIL sat arrival=%0d got det=%b cnt=%0d ovf=%b want det=1 cnt=%0d ovf=%b",
                         i, det_pulse, car_cnt, ovf, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1, (i == 15));
            end
            if (i < 15) repeat (5) tick();
        end
        // Asynchronous reset in the middle of a clock period.
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if ({c, car_cnt, det_pulse, ovf} !== 7'd0) begin
            n_bad++;
            $display("FAIL async_rst got c=%b cnt=%0d det=%b ovf=%b want all 0",
                     c, car_cnt, det_pulse, ovf);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        int raw_left, fg_left;
        raw_left = 0; fg_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (raw_left == 0) begin
                sensor_raw = ~sensor_raw;
                raw_left = $urandom_range(1, 9);
            end
            if (fg_left == 0) begin
                FG = ($urandom_range(0, 2) == 0);
                fg_left = $urandom_range(1, 20);
            end
            raw_left--; fg_left--;
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
            n_total++;
            if (c !== 1'(m_c) || car_cnt !== 4'(m_cnt) || det_pulse !== 1'(m_det)
                || ovf !== 1'(m_ovf)) begin
                n_bad++;
                $display("FAIL random cyc=%0d got c=%b cnt=%0d det=%b ovf=%b want c=%0d cnt=%0d det=%0d ovf=%0d",
                         n, c, car_cnt, det_pulse, ovf, m_c, m_cnt, m_det, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_arrival();
        test_reset();
        test_glitch();
        test_drain();
        test_timeout();
        test_back_to_back();
        test_reset();
        test_saturate();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
